// File: rtl/glitch_filter_pkg.sv
// Shared types and defaults for the glitch filter / rise counter block.
package glitch_filter_pkg;

    typedef enum logic [1:0] {
        LOW        = 2'd0,
        CHECK_HIGH = 2'd1,
        HIGH       = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 3;
    localparam int DEF_CNT_W         = 8;
    // Stability counter width; covers STABLE_CYCLES up to 15.
    localparam int STAB_W            = 4;

endpackage

// File: rtl/glitch_filter_count_sync2.sv
// Two-flop synchronizer for the asynchronous gate-stage output.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/glitch_filter_count.sv
// Debounces y_in, pulses on accepted rises, counts them and offers each
// count as a ready/valid event record with a sticky drop flag.
//
// state      | meaning
// LOW        | filtered level 0, input agrees
// CHECK_HIGH | filtered level 0, input high for r_stab samples
// HIGH       | filtered level 1, input agrees
// CHECK_LOW  | filtered level 1, input low for r_stab samples
module glitch_filter_count
    import glitch_filter_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             y_in,
    input  logic             clear,
    output logic             y_filt,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] count,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_data,
    output logic             overflow
);

    localparam logic [STAB_W-1:0] STAB_TC = STAB_W'(STABLE_CYCLES);

    logic              w_s2;
    state_t            r_state;
    state_t            w_state_next;
    logic [STAB_W-1:0] r_stab;
    logic [STAB_W-1:0] w_stab_next;
    logic [STAB_W-1:0] w_stab_inc;
    logic              w_filt;
    logic              w_filt_next;
    logic              r_rise;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_evt_valid;
    logic [CNT_W-1:0]  r_evt_data;
    logic              r_overflow;

    sync2 u_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (y_in),
        .q       (w_s2)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LOW;
            r_stab  <= '0;
        end else begin
            r_state <= w_state_next;
            r_stab  <= w_stab_next;
        end
    end

    assign w_stab_inc = r_stab + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_stab_next  = r_stab;
        case (r_state)
            LOW: begin
                if (w_s2) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_next = HIGH;
                        w_stab_next  = '0;
                    end else begin
                        w_state_next = CHECK_HIGH;
                        w_stab_next  = STAB_W'(1);
                    end
                end
            end
            CHECK_HIGH: begin
                if (!w_s2) begin
                    w_state_next = LOW;
                    w_stab_next  = '0;
                end else if (w_stab_inc == STAB_TC) begin
                    w_state_next = HIGH;
                    w_stab_next  = '0;
                end else begin
                    w_stab_next  = w_stab_inc;
                end
            end
            HIGH: begin
                if (!w_s2) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_next = LOW;
                        w_stab_next  = '0;
                    end else begin
                        w_state_next = CHECK_LOW;
                        w_stab_next  = STAB_W'(1);
                    end
                end
            end
            CHECK_LOW: begin
                if (w_s2) begin
                    w_state_next = HIGH;
                    w_stab_next  = '0;
                end else if (w_stab_inc == STAB_TC) begin
                    w_state_next = LOW;
                    w_stab_next  = '0;
                end else begin
                    w_stab_next  = w_stab_inc;
                end
            end
            default: begin
                w_state_next = LOW;
                w_stab_next  = '0;
            end
        endcase
    end

    always_comb begin
        w_filt      = (r_state == HIGH) || (r_state == CHECK_LOW);
        w_filt_next = (w_state_next == HIGH) || (w_state_next == CHECK_LOW);
    end

    // Registered so the pulse occupies the cycle after y_filt rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rise <= 1'b0;
        else          r_rise <= w_filt_next & ~w_filt;
    end

    assign w_cnt_inc = (r_count == '1) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_evt_valid <= 1'b0;
            r_evt_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (clear)       r_count <= '0;
            else if (r_rise) r_count <= w_cnt_inc;

            // A clear coinciding with a rise swallows that rise entirely.
            if (r_rise && !clear) begin
                if (!r_evt_valid || evt_ready) begin
                    r_evt_valid <= 1'b1;
                    r_evt_data  <= w_cnt_inc;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (evt_ready) begin
                r_evt_valid <= 1'b0;
            end

            if (clear) r_overflow <= 1'b0;
        end
    end

    assign y_filt     = w_filt;
    assign rise_pulse = r_rise;
    assign count      = r_count;
    assign evt_valid  = r_evt_valid;
    assign evt_data   = r_evt_data;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_glitch_filter_count.sv
// Directed bench for glitch_filter_count with STABLE_CYCLES=3, CNT_W=8.
module tb_glitch_filter_count;
    import glitch_filter_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             y_in;
    logic             clear;
    logic             evt_ready;
    logic             y_filt;
    logic             rise_pulse;
    logic [CNT_W-1:0] count;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_data;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    glitch_filter_count #(.STABLE_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .y_in       (y_in),
        .clear      (clear),
        .y_filt     (y_filt),
        .rise_pulse (rise_pulse),
        .count      (count),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rise();
        y_in = 1'b1;
        repeat (6) tick();
        y_in = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        logic seen_high;

        reset_n   = 1'b0;
        y_in      = 1'b1;
        clear     = 1'b0;
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("rst_y_filt", 32'(y_filt), 0);
        chk("rst_rise", 32'(rise_pulse), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_data", 32'(evt_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_state", 32'(dut.r_state), 32'(LOW));

        y_in    = 1'b0;
        reset_n = 1'b1;
        repeat (4) tick();
        chk("idle_y_filt", 32'(y_filt), 0);

        // rise latency: change sampled at edge k, y_filt at k+4
        y_in = 1'b1;
        repeat (4) tick();
        chk("lat_pre_y_filt", 32'(y_filt), 0);
        tick();
        chk("lat_y_filt", 32'(y_filt), 1);
        chk("lat_rise", 32'(rise_pulse), 1);
        chk("lat_count_pre", 32'(count), 0);
        tick();
        chk("lat_rise_off", 32'(rise_pulse), 0);
        chk("lat_count", 32'(count), 1);
        chk("lat_evt_valid", 32'(evt_valid), 1);
        chk("lat_evt_data", 32'(evt_data), 1);
        tick();
        chk("ack_evt_valid", 32'(evt_valid), 0);
        chk("ack_evt_data", 32'(evt_data), 1);

        // falling edge: same latency, no pulse
        y_in = 1'b0;
        repeat (4) tick();
        chk("fall_pre_y_filt", 32'(y_filt), 1);
        tick();
        chk("fall_y_filt", 32'(y_filt), 0);
        chk("fall_rise", 32'(rise_pulse), 0);
        tick();
        chk("fall_rise2", 32'(rise_pulse), 0);
        chk("fall_count", 32'(count), 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_count", 32'(count), 0);

        // 2-cycle glitch must be rejected
        seen_high = 1'b0;
        y_in = 1'b1;
        repeat (2) tick();
        y_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y_filt) seen_high = 1'b1;
        end
        chk("glitch_y_filt", 32'(seen_high), 0);
        chk("glitch_count", 32'(count), 0);
        chk("glitch_evt_valid", 32'(evt_valid), 0);

        // exactly 3 cycles high is accepted
        seen_high = 1'b0;
        y_in = 1'b1;
        repeat (3) tick();
        y_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (y_filt) seen_high = 1'b1;
        end
        chk("edge3_seen", 32'(seen_high), 1);
        chk("edge3_count", 32'(count), 1);
        chk("edge3_y_filt", 32'(y_filt), 0);

        // back-pressure: second rise dropped
        clear = 1'b1;
        tick();
        clear = 1'b0;
        evt_ready = 1'b0;
        do_rise();
        do_rise();
        chk("bp_evt_valid", 32'(evt_valid), 1);
        chk("bp_evt_data", 32'(evt_data), 1);
        chk("bp_count", 32'(count), 2);
        chk("bp_overflow", 32'(overflow), 1);
        evt_ready = 1'b1;
        tick();
        chk("bp_ack_valid", 32'(evt_valid), 0);
        chk("bp_ovf_sticky", 32'(overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("bp_clr_ovf", 32'(overflow), 0);
        chk("bp_clr_count", 32'(count), 0);

        // saturation
        for (int i = 0; i < 255; i++) do_rise();
        chk("sat255_count", 32'(count), 255);
        chk("sat255_data", 32'(evt_data), 255);
        do_rise();
        chk("sat256_count", 32'(count), 255);
        chk("sat256_data", 32'(evt_data), 255);
        chk("sat256_ovf", 32'(overflow), 0);

        // clear coincident with rise_pulse
        y_in = 1'b1;
        repeat (5) tick();
        chk("coin_rise", 32'(rise_pulse), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("coin_count", 32'(count), 0);
        chk("coin_ovf", 32'(overflow), 0);
        chk("coin_evt_valid", 32'(evt_valid), 0);
        chk("coin_evt_data", 32'(evt_data), 255);
        y_in = 1'b0;
        repeat (8) tick();

        // reset asserted while in CHECK_HIGH
        y_in = 1'b1;
        repeat (3) tick();
        chk("mid_state_pre", 32'(dut.r_state), 32'(CHECK_HIGH));
        reset_n = 1'b0;
        #1;
        chk("mid_state_rst", 32'(dut.r_state), 32'(LOW));
        chk("mid_y_filt", 32'(y_filt), 0);
        chk("mid_rise", 32'(rise_pulse), 0);
        chk("mid_count", 32'(count), 0);
        chk("mid_evt_data", 32'(evt_data), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_pre", 32'(y_filt), 0);
        tick();
        chk("post_rst_y_filt", 32'(y_filt), 1);
        tick();
        chk("post_rst_count", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_filter_count.md
GLITCH_FILTER_COUNT -- requirements
Module: glitch_filter_count

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3: consecutive synchronized samples needed to accept a level change; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the event counter and of evt_data.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port y_in  input  1  raw, possibly glitching output of the upstream combinational gate stage, asynchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous clear of count and overflow.
REQ-007 SHALL have port y_filt  output  1  filtered, synchronized level of y_in.
REQ-008 SHALL have port rise_pulse  output  1  one-cycle pulse on each accepted 0->1 transition of y_filt.
REQ-009 SHALL have port count  output  CNT_W  number of accepted rises since reset/clear, saturating.
REQ-010 SHALL have port evt_valid  output  1  event record available.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts the record.
REQ-012 SHALL have port evt_data  output  CNT_W  count value after the rise that produced the event.
REQ-013 SHALL have port overflow  output  1  sticky flag; an event was dropped.

Function
REQ-014 SHALL pass y_in through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 SHALL implement FSM states LOW, CHECK_HIGH, HIGH, CHECK_LOW; y_filt = 1 in HIGH and CHECK_LOW, else 0.
REQ-016 In LOW, s2=1 SHALL move to CHECK_HIGH with stability counter = 1; s2=0 stays LOW.
REQ-017 In CHECK_HIGH, s2=1 SHALL increment the counter; when it would reach STABLE_CYCLES, move to HIGH and clear counter; s2=0 SHALL return to LOW and clear counter.
REQ-018 HIGH/CHECK_LOW SHALL behave symmetrically with s2 inverted.
REQ-019 For STABLE_CYCLES=1, LOW SHALL go directly to HIGH on s2=1 (and HIGH to LOW on s2=0).
REQ-020 Latency: for a stable y_in change first sampled at edge k, y_filt SHALL change at edge k+1+STABLE_CYCLES.
REQ-021 Changes shorter than STABLE_CYCLES synchronized samples SHALL NOT change y_filt.
REQ-022 rise_pulse SHALL be high for exactly the cycle following the edge where y_filt goes 0->1; no pulse on 1->0.
REQ-023 count SHALL increment on rise_pulse and saturate at 2^CNT_W-1.
REQ-024 clear SHALL zero count and overflow at the next edge; clear and rise_pulse in the same cycle SHALL leave count = 0 and no event loaded; clear SHALL NOT affect FSM, y_filt or a pending event.
REQ-025 On rise_pulse, if evt_valid=0 or (evt_valid=1 and evt_ready=1), SHALL load evt_data = new count and set evt_valid.
REQ-026 On rise_pulse with evt_valid=1 and evt_ready=0, SHALL drop the event, keep evt_data unchanged, set overflow.
REQ-027 evt_valid and evt_data SHALL remain stable until a cycle with evt_ready=1; evt_valid SHALL clear at that edge unless REQ-025 reloads.
REQ-028 evt_valid SHALL NOT depend combinationally on evt_ready.

Reset
REQ-029 reset_n=0 SHALL immediately clear s1, s2, stability counter, count, evt_data, evt_valid, overflow, rise_pulse, and force state LOW (y_filt=0), including mid-CHECK.
REQ-030 After reset_n deasserts, the first change SHALL obey REQ-020 latency.

Structure
REQ-031 Package glitch_filter_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-032 Synchronizer SHALL be sub-module sync2 (clk, reset_n, d, q); everything else in glitch_filter_count.

Verification (STABLE_CYCLES=3, CNT_W=8)
REQ-033 Reset with y_in=1, reset_n low 3 cycles -> all outputs 0, state LOW.
REQ-034 y_in 0->1 sampled at edge 10, held -> y_filt=1 at edge 14, rise_pulse one cycle, count=1, evt_valid=1, evt_data=1.
REQ-035 y_in high 2 cycles then low -> y_filt stays 0, count=0, no event.
REQ-036 evt_ready=0, two clean rises -> evt_data=1 held, count=2, overflow=1; then evt_ready=1 -> evt_valid=0 next edge.
REQ-037 256 clean rises with evt_ready=1 -> count saturates at 255; clear coincident with a rise -> count=0, overflow=0.
REQ-038 reset_n pulsed low during CHECK_HIGH -> state LOW at once, no rise_pulse, count=0.
